// File: rtl/vlc_frame_ctrl_pkg.sv
// rtl/vlc_frame_ctrl_pkg.sv - shared phase encodings and default frame lengths
// Contents: phase_e (PH_IDLE/PH_PRE/PH_PAY/PH_GUARD), PRE_LEN_DEF, GUARD_LEN_DEF,
//           next_phase() giving the fixed preamble -> payload -> guard -> idle order.
package vlc_frame_ctrl_pkg;

   typedef enum logic [1:0] {
      PH_IDLE  = 2'b00,
      PH_PRE   = 2'b01,
      PH_PAY   = 2'b10,
      PH_GUARD = 2'b11
   } phase_e;

   // The modulator reads these defaults too, so keep them here rather than in the top.
   localparam int PRE_LEN_DEF   = 16;
   localparam int GUARD_LEN_DEF = 4;

   function automatic phase_e next_phase(input phase_e p);
      case (p)
         PH_PRE:  return PH_PAY;
         PH_PAY:  return PH_GUARD;
         default: return PH_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/vlc_frame_ctrl_if.sv
// rtl/vlc_frame_ctrl_if.sv - host/modulator signal bundle of the frame sequencer
// Host side (master): drives start, abort, len, div; observes the rest.
// Sequencer side (slave): drives busy, phase, sym_tick, sym_idx, done.
interface vlc_frame_ctrl_if #(
   parameter int C_WIDTH   = 10,
   parameter int DIV_WIDTH = 8
);
   logic                 start;
   logic                 abort;
   logic [C_WIDTH-1:0]   len;
   logic [DIV_WIDTH-1:0] div;
   logic                 busy;
   logic [1:0]           phase;
   logic                 sym_tick;
   logic [C_WIDTH-1:0]   sym_idx;
   logic                 done;

   modport master (
      output start, abort, len, div,
      input  busy, phase, sym_tick, sym_idx, done
   );

   modport slave (
      input  start, abort, len, div,
      output busy, phase, sym_tick, sym_idx, done
   );
endinterface

// File: rtl/vlc_frame_ctrl_sym_prescaler.sv
// rtl/vlc_frame_ctrl_sym_prescaler.sv - symbol-period up-counter with terminal-count compare
// Ports: c_clk, c_reset (async, high); clr (sync clear, wins over en); en (count);
//        div_q (terminal value); tc (count == div_q, decoded from the count register).
module sym_prescaler #(
   parameter int DIV_WIDTH = 8
) (
   input  logic                 c_clk,
   input  logic                 c_reset,
   input  logic                 clr,
   input  logic                 en,
   input  logic [DIV_WIDTH-1:0] div_q,
   output logic                 tc
);
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

   assign tc = (cnt_q == div_q);

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en)
         cnt_d = tc ? '0 : cnt_q + DIV_WIDTH'(1);
   end

   always_ff @(posedge c_clk or posedge c_reset) begin
      if (c_reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end
endmodule

// File: rtl/vlc_frame_ctrl.sv
// rtl/vlc_frame_ctrl.sv - transmit-frame sequencer: preamble, payload, guard at a prescaled symbol rate
// Ports: c_clk (rising edge), c_reset (async, high), bus (slave modport):
//        start/abort/len/div in; busy/phase/sym_tick/sym_idx/done out.
// All outputs are decoded from registers, so none has a combinational path from an input.
module vlc_frame_ctrl
   import vlc_frame_ctrl_pkg::*;
#(
   parameter int C_WIDTH   = 10,
   parameter int DIV_WIDTH = 8,
   parameter int PRE_LEN   = PRE_LEN_DEF,
   parameter int GUARD_LEN = GUARD_LEN_DEF
) (
   input  logic             c_clk,
   input  logic             c_reset,
   vlc_frame_ctrl_if.slave  bus
);
   localparam logic [C_WIDTH-1:0] PRE_LAST   = C_WIDTH'(PRE_LEN - 1);
   localparam logic [C_WIDTH-1:0] GUARD_LAST = C_WIDTH'(GUARD_LEN - 1);

   phase_e               state_q, state_d;
   logic [C_WIDTH-1:0]   sym_idx_q, sym_idx_d;
   logic [C_WIDTH-1:0]   len_q, len_d;
   logic [DIV_WIDTH-1:0] div_q, div_d;
   logic                 done_q, done_d;
   logic                 busy;
   logic                 tc;
   logic                 sym_tick;
   logic                 pre_clr;
   logic [C_WIDTH-1:0]   last_idx;

   assign busy     = (state_q != PH_IDLE);
   assign sym_tick = busy && tc;

   sym_prescaler #(.DIV_WIDTH(DIV_WIDTH)) u_prescaler (
      .c_clk   (c_clk),
      .c_reset (c_reset),
      .clr     (pre_clr),
      .en      (busy),
      .div_q   (div_q),
      .tc      (tc)
   );

   always_comb begin
      case (state_q)
         PH_PRE:  last_idx = PRE_LAST;
         PH_PAY:  last_idx = len_q - C_WIDTH'(1);
         default: last_idx = GUARD_LAST;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      sym_idx_d = sym_idx_q;
      len_d     = len_q;
      div_d     = div_q;
      done_d    = 1'b0;
      pre_clr   = 1'b0;
      if (state_q == PH_IDLE) begin
         // abort is meaningless in IDLE, so a coincident start is simply taken
         if (bus.start && (bus.len != '0)) begin
            state_d   = PH_PRE;
            len_d     = bus.len;
            div_d     = bus.div;
            sym_idx_d = '0;
            pre_clr   = 1'b1;
         end
      end else if (bus.abort) begin
         // abort beats the final guard tick, so no done on a cancelled frame
         state_d   = PH_IDLE;
         sym_idx_d = '0;
         pre_clr   = 1'b1;
      end else if (sym_tick) begin
         if (sym_idx_q == last_idx) begin
            state_d   = next_phase(state_q);
            sym_idx_d = '0;
            done_d    = (state_q == PH_GUARD);
         end else begin
            sym_idx_d = sym_idx_q + C_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge c_clk or posedge c_reset) begin
      if (c_reset) begin
         state_q   <= PH_IDLE;
         sym_idx_q <= '0;
         len_q     <= '0;
         div_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sym_idx_q <= sym_idx_d;
         len_q     <= len_d;
         div_q     <= div_d;
         done_q    <= done_d;
      end
   end

   assign bus.busy     = busy;
   assign bus.phase    = state_q;
   assign bus.sym_tick = sym_tick;
   assign bus.sym_idx  = sym_idx_q;
   assign bus.done     = done_q;
endmodule

// File: tb/tb_vlc_frame_ctrl.sv
// tb/tb_vlc_frame_ctrl.sv - directed self-checking bench for vlc_frame_ctrl
module tb_vlc_frame_ctrl;
   logic c_clk;
   logic c_reset;
   int   n_checks;
   int   n_fail;

   vlc_frame_ctrl_if #(.C_WIDTH(10), .DIV_WIDTH(8)) bus ();

   vlc_frame_ctrl #(
      .C_WIDTH   (10),
      .DIV_WIDTH (8),
      .PRE_LEN   (16),
      .GUARD_LEN (4)
   ) dut (
      .c_clk   (c_clk),
      .c_reset (c_reset),
      .bus     (bus)
   );

   initial c_clk = 1'b0;
   always #5 c_clk = ~c_clk;

   int m_busy, m_ticks, m_pre, m_pay, m_guard, m_done_busy;
   int m_done_end, m_done_after, m_max_pay, m_first_guard;
   int obs_idx[$];
   int exp_idx[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge c_clk);
      #1;
   endtask

   // Leaves the bench one cycle after the start edge, i.e. on the first busy cycle.
   task automatic issue(input int l, input int d);
      bus.start = 1'b1;
      bus.len   = 10'(l);
      bus.div   = 8'(d);
      step();
      bus.start = 1'b0;
   endtask

   // Samples from the current cycle until busy drops, then one more cycle for the done pulse width.
   task automatic measure(input int max_cycles);
      bit ended;
      bit seen_guard;
      ended = 0;
      seen_guard = 0;
      m_busy = 0; m_ticks = 0; m_pre = 0; m_pay = 0; m_guard = 0; m_done_busy = 0;
      m_done_end = 0; m_done_after = 0; m_max_pay = 0; m_first_guard = -1;
      obs_idx.delete();
      for (int i = 0; i < max_cycles; i++) begin
         if (!bus.busy) begin
            m_done_end = int'(bus.done);
            ended = 1;
            break;
         end
         m_busy++;
         obs_idx.push_back(int'(bus.sym_idx));
         if (bus.sym_tick) m_ticks++;
         if (bus.done) m_done_busy++;
         case (bus.phase)
            2'b01: m_pre++;
            2'b10: begin
               m_pay++;
               if (int'(bus.sym_idx) > m_max_pay) m_max_pay = int'(bus.sym_idx);
            end
            2'b11: begin
               m_guard++;
               if (!seen_guard) m_first_guard = int'(bus.sym_idx);
               seen_guard = 1;
            end
            default: ;
         endcase
         step();
      end
      check_eq("frame_end_in_budget", 32'(ended), 32'd1);
      step();
      m_done_after = int'(bus.done);
   endtask

   task automatic wait_for(input logic [1:0] ph, input int idx, input bit need_tick,
                           input int max_cycles, output bit found);
      found = 0;
      for (int i = 0; i < max_cycles; i++) begin
         if (bus.phase == ph && int'(bus.sym_idx) == idx && (!need_tick || bus.sym_tick)) begin
            found = 1;
            break;
         end
         step();
      end
   endtask

   initial begin
      bit found;
      n_checks = 0;
      n_fail   = 0;
      c_reset   = 1'b1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.len   = '0;
      bus.div   = '0;
      #12;
      check_eq("rst_busy", 32'(bus.busy), 0);
      check_eq("rst_phase", 32'(bus.phase), 0);
      check_eq("rst_tick", 32'(bus.sym_tick), 0);
      check_eq("rst_idx", 32'(bus.sym_idx), 0);
      check_eq("rst_done", 32'(bus.done), 0);
      c_reset = 1'b0;
      step();

      // Nominal frame: div=1, len=3
      issue(3, 1);
      check_eq("t1_first_phase", 32'(bus.phase), 1);
      check_eq("t1_first_tick", 32'(bus.sym_tick), 0);
      measure(200);
      check_eq("t1_busy_cycles", m_busy, 46);
      check_eq("t1_ticks", m_ticks, 23);
      check_eq("t1_pre", m_pre, 32);
      check_eq("t1_pay", m_pay, 6);
      check_eq("t1_guard", m_guard, 8);
      check_eq("t1_done_busy", m_done_busy, 0);
      check_eq("t1_done_end", m_done_end, 1);
      check_eq("t1_done_after", m_done_after, 0);

      // Fastest symbols: div=0, len=1
      exp_idx.delete();
      for (int i = 0; i < 16; i++) exp_idx.push_back(i);
      exp_idx.push_back(0);
      for (int i = 0; i < 4; i++) exp_idx.push_back(i);
      issue(1, 0);
      measure(100);
      check_eq("t2_busy_cycles", m_busy, 21);
      check_eq("t2_ticks", m_ticks, 21);
      check_eq("t2_idx_count", obs_idx.size(), exp_idx.size());
      for (int i = 0; i < exp_idx.size() && i < obs_idx.size(); i++)
         check_eq($sformatf("t2_idx[%0d]", i), obs_idx[i], exp_idx[i]);
      check_eq("t2_done_end", m_done_end, 1);
      check_eq("t2_done_after", m_done_after, 0);

      // Abort mid-payload
      issue(10, 3);
      wait_for(2'b10, 5, 0, 400, found);
      check_eq("t3_reach_pay5", 32'(found), 1);
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      check_eq("t3_busy", 32'(bus.busy), 0);
      check_eq("t3_phase", 32'(bus.phase), 0);
      check_eq("t3_idx", 32'(bus.sym_idx), 0);
      check_eq("t3_done", 32'(bus.done), 0);
      step();
      check_eq("t3_done_next", 32'(bus.done), 0);

      // Abort on the final guard tick
      issue(10, 3);
      wait_for(2'b11, 3, 1, 400, found);
      check_eq("t3b_reach_last_tick", 32'(found), 1);
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      check_eq("t3b_busy", 32'(bus.busy), 0);
      check_eq("t3b_done", 32'(bus.done), 0);
      step();
      check_eq("t3b_done_next", 32'(bus.done), 0);

      // start with len=0 is ignored
      bus.start = 1'b1;
      bus.len   = '0;
      bus.div   = '0;
      step();
      bus.start = 1'b0;
      check_eq("t4_len0_busy", 32'(bus.busy), 0);
      check_eq("t4_len0_phase", 32'(bus.phase), 0);

      // start while busy does not relatch len or div
      issue(3, 0);
      bus.start = 1'b1;
      bus.len   = 10'd7;
      bus.div   = 8'd5;
      step(); step(); step();
      bus.start = 1'b0;
      measure(200);
      check_eq("t4_busy_rest", m_busy, 20);
      check_eq("t4_pre_rest", m_pre, 13);
      check_eq("t4_pay", m_pay, 3);
      check_eq("t4_ticks_rest", m_ticks, 20);
      check_eq("t4_done_end", m_done_end, 1);

      // start and abort together in IDLE: start wins
      bus.start = 1'b1;
      bus.abort = 1'b1;
      bus.len   = 10'd2;
      bus.div   = 8'd0;
      step();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      check_eq("t4_sa_busy", 32'(bus.busy), 1);
      check_eq("t4_sa_phase", 32'(bus.phase), 1);
      measure(100);
      check_eq("t4_sa_busy_cycles", m_busy, 22);

      // Reset between edges during payload
      issue(3, 1);
      wait_for(2'b10, 1, 0, 200, found);
      check_eq("t5_reach_pay", 32'(found), 1);
      #3;
      c_reset = 1'b1;
      #1;
      check_eq("t5_rst_busy", 32'(bus.busy), 0);
      check_eq("t5_rst_phase", 32'(bus.phase), 0);
      check_eq("t5_rst_idx", 32'(bus.sym_idx), 0);
      check_eq("t5_rst_tick", 32'(bus.sym_tick), 0);
      check_eq("t5_rst_done", 32'(bus.done), 0);
      #1;
      c_reset = 1'b0;
      step();
      check_eq("t5_idle_after", 32'(bus.busy), 0);
      issue(2, 0);
      measure(100);
      check_eq("t5_busy_cycles", m_busy, 22);
      check_eq("t5_done_end", m_done_end, 1);
      check_eq("t5_done_after", m_done_after, 0);

      // Width limit: len=1023
      issue(1023, 0);
      measure(1200);
      check_eq("t6_busy_cycles", m_busy, 1043);
      check_eq("t6_pay", m_pay, 1023);
      check_eq("t6_max_pay_idx", m_max_pay, 1022);
      check_eq("t6_first_guard_idx", m_first_guard, 0);
      check_eq("t6_done_end", m_done_end, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
